// File: rtl/mt_param_if.sv
// Rename-stage bus for mt_param: dispatch group, CDB lanes, checkpoint control
// and the renamed results returned to the dispatch stage.
interface mt_param_if #(
  parameter int unsigned PR_BITS    = 7,
  parameter int unsigned DISPATCH_W = 2,
  parameter int unsigned CDB_W      = 4,
  parameter int unsigned NUM_CKPT   = 4
) ();
  localparam int unsigned AR_W  = 5;
  localparam int unsigned DN_W  = $clog2(DISPATCH_W + 1);
  localparam int unsigned CS_W  = (DISPATCH_W > 1) ? $clog2(DISPATCH_W) : 1;
  localparam int unsigned PTR_W = (NUM_CKPT > 1) ? $clog2(NUM_CKPT) : 1;

  logic [DN_W-1:0]               disp_num;
  logic [DISPATCH_W-1:0]         dest_valid;
  logic [DISPATCH_W*AR_W-1:0]    dest_ar;
  logic [DISPATCH_W*AR_W-1:0]    src1_ar;
  logic [DISPATCH_W*AR_W-1:0]    src2_ar;
  logic [DISPATCH_W*PR_BITS-1:0] fl_pr;
  logic [CDB_W-1:0]              cdb_valid;
  logic [CDB_W*PR_BITS-1:0]      cdb_pr;
  logic                          ckpt_take;
  logic [CS_W-1:0]               ckpt_slot;
  logic                          ckpt_release;
  logic                          recover;
  logic [PTR_W-1:0]              recover_tag;

  logic [DISPATCH_W*PR_BITS-1:0] told;
  logic [DISPATCH_W*PR_BITS-1:0] src1_pr;
  logic [DISPATCH_W*PR_BITS-1:0] src2_pr;
  logic [DISPATCH_W-1:0]         src1_ready;
  logic [DISPATCH_W-1:0]         src2_ready;
  logic [PTR_W-1:0]              ckpt_tag;
  logic                          ckpt_full;

  modport master (
    output disp_num, dest_valid, dest_ar, src1_ar, src2_ar, fl_pr,
           cdb_valid, cdb_pr, ckpt_take, ckpt_slot, ckpt_release,
           recover, recover_tag,
    input  told, src1_pr, src2_pr, src1_ready, src2_ready, ckpt_tag, ckpt_full
  );

  modport slave (
    input  disp_num, dest_valid, dest_ar, src1_ar, src2_ar, fl_pr,
           cdb_valid, cdb_pr, ckpt_take, ckpt_slot, ckpt_release,
           recover, recover_tag,
    output told, src1_pr, src2_pr, src1_ready, src2_ready, ckpt_tag, ckpt_full
  );
endinterface

// File: rtl/mt_param.sv
// Register map table with per-PR ready bits and a circular checkpoint buffer.
// Optional MT_CDB_BYPASS_EN: same-cycle CDB completions mark sources ready.
module mt_param #(
  parameter int unsigned NUM_AR     = 32,
  parameter int unsigned PR_BITS    = 7,
  parameter int unsigned DISPATCH_W = 2,
  parameter int unsigned CDB_W      = 4,
  parameter int unsigned NUM_CKPT   = 4
) (
  input  logic       clock,
  input  logic       reset,
  mt_param_if.slave  bus
);
  localparam int unsigned AR_W   = 5;
  localparam int unsigned NUM_PR = 1 << PR_BITS;
  localparam int unsigned DN_W   = $clog2(DISPATCH_W + 1);
  localparam int unsigned CS_W   = (DISPATCH_W > 1) ? $clog2(DISPATCH_W) : 1;
  localparam int unsigned PTR_W  = (NUM_CKPT > 1) ? $clog2(NUM_CKPT) : 1;
  localparam int unsigned CNT_W  = $clog2(NUM_CKPT + 1);

  typedef logic [PR_BITS-1:0] pr_t;
  typedef logic [AR_W-1:0]    ar_t;

  pr_t               map_q [NUM_AR];
  pr_t               map_d [NUM_AR];
  pr_t               snap_c [NUM_AR];
  pr_t               ckpt_q [NUM_CKPT][NUM_AR];
  logic [NUM_PR-1:0] ready_q, ready_d;
  logic [PTR_W-1:0]  head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              full_c, rel_c, take_ok_c;

  logic              wr_v [DISPATCH_W];
  ar_t               dest_a [DISPATCH_W];
  ar_t               s1_a [DISPATCH_W];
  ar_t               s2_a [DISPATCH_W];
  pr_t               fl_a [DISPATCH_W];
  pr_t               cdb_a [CDB_W];
  pr_t               told_a [DISPATCH_W];
  pr_t               s1pr_a [DISPATCH_W];
  pr_t               s2pr_a [DISPATCH_W];
  logic              s1fwd [DISPATCH_W];
  logic              s2fwd [DISPATCH_W];
  logic              hit1 [DISPATCH_W];
  logic              hit2 [DISPATCH_W];

  logic [DISPATCH_W*PR_BITS-1:0] told_c, src1_pr_c, src2_pr_c;
  logic [DISPATCH_W-1:0]         src1_ready_c, src2_ready_c;

  // Unpack the flat per-slot and per-lane buses.
  always_comb begin
    for (int s = 0; s < DISPATCH_W; s++) begin
      wr_v[s]   = (DN_W'(s) < bus.disp_num) && bus.dest_valid[s];
      dest_a[s] = bus.dest_ar[s*AR_W +: AR_W];
      s1_a[s]   = bus.src1_ar[s*AR_W +: AR_W];
      s2_a[s]   = bus.src2_ar[s*AR_W +: AR_W];
      fl_a[s]   = bus.fl_pr[s*PR_BITS +: PR_BITS];
    end
    for (int l = 0; l < CDB_W; l++) cdb_a[l] = bus.cdb_pr[l*PR_BITS +: PR_BITS];
  end

  // Lookup from the registered map; later older slots override earlier ones.
  always_comb begin
    for (int s = 0; s < DISPATCH_W; s++) begin
      told_a[s] = map_q[dest_a[s]];
      s1pr_a[s] = map_q[s1_a[s]];
      s2pr_a[s] = map_q[s2_a[s]];
      s1fwd[s]  = 1'b0;
      s2fwd[s]  = 1'b0;
      for (int j = 0; j < s; j++) begin
        if (wr_v[j]) begin
          if (dest_a[j] == dest_a[s]) told_a[s] = fl_a[j];
          if (dest_a[j] == s1_a[s]) begin
            s1pr_a[s] = fl_a[j];
            s1fwd[s]  = 1'b1;
          end
          if (dest_a[j] == s2_a[s]) begin
            s2pr_a[s] = fl_a[j];
            s2fwd[s]  = 1'b1;
          end
        end
      end
    end
  end

  always_comb begin
    for (int s = 0; s < DISPATCH_W; s++) begin
      hit1[s] = 1'b0;
      hit2[s] = 1'b0;
`ifdef MT_CDB_BYPASS_EN
      for (int l = 0; l < CDB_W; l++) begin
        if (bus.cdb_valid[l] && cdb_a[l] == s1pr_a[s]) hit1[s] = 1'b1;
        if (bus.cdb_valid[l] && cdb_a[l] == s2pr_a[s]) hit2[s] = 1'b1;
      end
`endif
    end
  end

  always_comb begin
    told_c       = '0;
    src1_pr_c    = '0;
    src2_pr_c    = '0;
    src1_ready_c = '0;
    src2_ready_c = '0;
    for (int s = 0; s < DISPATCH_W; s++) begin
      told_c[s*PR_BITS +: PR_BITS]    = told_a[s];
      src1_pr_c[s*PR_BITS +: PR_BITS] = s1pr_a[s];
      src2_pr_c[s*PR_BITS +: PR_BITS] = s2pr_a[s];
      src1_ready_c[s] = !s1fwd[s] && (ready_q[s1pr_a[s]] || hit1[s]);
      src2_ready_c[s] = !s2fwd[s] && (ready_q[s2pr_a[s]] || hit2[s]);
    end
  end

  assign bus.told       = told_c;
  assign bus.src1_pr    = src1_pr_c;
  assign bus.src2_pr    = src2_pr_c;
  assign bus.src1_ready = src1_ready_c;
  assign bus.src2_ready = src2_ready_c;
  assign bus.ckpt_tag   = tail_q;
  assign bus.ckpt_full  = full_c;

  // Map/ready update; CDB sets go first so a dispatch clear to the same tag wins.
  always_comb begin
    map_d   = map_q;
    snap_c  = map_q;
    ready_d = ready_q;
    for (int l = 0; l < CDB_W; l++) begin
      if (bus.cdb_valid[l]) ready_d[cdb_a[l]] = 1'b1;
    end
    if (bus.recover) begin
      map_d = ckpt_q[bus.recover_tag];
    end else begin
      for (int s = 0; s < DISPATCH_W; s++) begin
        if (wr_v[s]) begin
          map_d[dest_a[s]] = fl_a[s];
          ready_d[fl_a[s]] = 1'b0;
        end
        if (CS_W'(s) == bus.ckpt_slot) snap_c = map_d;
      end
    end
  end

  // Checkpoint FIFO pointers; release is applied before any recover.
  always_comb begin
    full_c    = (count_q == CNT_W'(NUM_CKPT));
    rel_c     = bus.ckpt_release && (count_q != '0);
    take_ok_c = bus.ckpt_take && !full_c && !bus.recover && reset;
    head_d    = head_q + PTR_W'(rel_c);
    count_d   = count_q - CNT_W'(rel_c);
    tail_d    = tail_q;
    if (bus.recover) begin
      tail_d  = bus.recover_tag;
      count_d = CNT_W'(PTR_W'(bus.recover_tag - head_d));
    end else if (take_ok_c) begin
      tail_d  = tail_q + PTR_W'(1);
      count_d = count_d + CNT_W'(1);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_AR; i++) map_q[i] <= PR_BITS'(i);
      ready_q <= '1;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      map_q   <= map_d;
      ready_q <= ready_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Snapshot storage; validity is tracked solely by head/count.
  always_ff @(posedge clock) begin
    if (take_ok_c) ckpt_q[tail_q] <= snap_c;
  end
endmodule

// File: doc/mt_param.md
MT_PARAM -- requirements
Module: mt_param

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning):
- NUM_AR, 32, architectural registers; AR index 5 bits.
- PR_BITS, 7, physical register tag width.
- DISPATCH_W, 2, rename slots per cycle; slot 0 is oldest.
- CDB_W, 4, completion broadcast lanes.
- NUM_CKPT, 4, map checkpoints; power of 2.

REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- clock, in, 1, single clock; all state updates on the rising edge.
- reset, in, 1, asynchronous, active-low reset.
- disp_num, in, $clog2(DISPATCH_W+1), number of valid slots (0..DISPATCH_W), which occupy slots 0..disp_num-1.
- dest_valid, in, DISPATCH_W, slot writes a destination.
- dest_ar / src1_ar / src2_ar, in, DISPATCH_W*5 each, per-slot destination and source architectural registers.
- fl_pr, in, DISPATCH_W*PR_BITS, per-slot new physical register from the free list.
- cdb_valid, in, CDB_W, valid bit for each CDB lane.
- cdb_pr, in, CDB_W*PR_BITS, physical tag of each completing instruction.
- ckpt_take, in, 1, take a checkpoint this cycle.
- ckpt_slot, in, $clog2(DISPATCH_W), slot that carries the branch being checkpointed.
- ckpt_release, in, 1, free the oldest checkpoint (its branch resolved correctly).
- recover, in, 1, restore the map from checkpoint recover_tag.
- recover_tag, in, $clog2(NUM_CKPT), checkpoint to restore.
- told, out, DISPATCH_W*PR_BITS, previous mapping of each slot's destination.
- src1_pr / src2_pr, out, DISPATCH_W*PR_BITS each, renamed source tags.
- src1_ready / src2_ready, out, DISPATCH_W each, source value is available.
- ckpt_tag, out, $clog2(NUM_CKPT), ID of the checkpoint taken this cycle (= tail).
- ckpt_full, out, 1, all NUM_CKPT checkpoints are in use.

Function
REQ-003 Lookups SHALL be combinational and computed from the map as it stood before this cycle's writes; map writes SHALL take effect at the next rising edge.
REQ-004 Intra-group forwarding: a slot's told, src1_pr and src2_pr SHALL use the fl_pr of the youngest older slot in the same group whose valid dest_ar matches; a forwarded source SHALL report ready=0.
REQ-005 If several slots write the same AR in one cycle, the youngest write SHALL win in the map.
REQ-006 Ready state SHALL be one bit per physical register, indexed by tag:
- dispatch clears ready[fl_pr];
- a valid CDB lane sets ready[cdb_pr];
- if both hit the same tag in one cycle, the clear wins.
REQ-007 A checkpoint SHALL snapshot the map after slots 0..ckpt_slot are applied. Checkpoints SHALL be allocated at the tail, freed from the head, and tracked with a count of 0..NUM_CKPT. Pointers SHALL wrap modulo NUM_CKPT.
REQ-008 If ckpt_take is asserted while ckpt_full=1, the block SHALL ignore it and SHALL change no state for it.
REQ-009 On recover, the block SHALL:
- restore the map from recover_tag at the next edge;
- set tail = recover_tag, freeing that checkpoint and all younger ones;
- ignore dispatch and ckpt_take in the same cycle;
- leave the ready state unrestored.
REQ-010 If ckpt_release and recover occur in the same cycle, the release SHALL be applied first; if recover_tag equals the head, the count SHALL become 0.
REQ-011 ckpt_release with count=0 SHALL be ignored.

Reset
REQ-012 While reset=0, the block SHALL set map[i]=i, set every ready bit to 1, and set head=tail=count=0.
REQ-013 Consequently, with disp_num=0, told and the src outputs SHALL equal their AR index, ready outputs SHALL be 1, ckpt_full=0 and ckpt_tag=0.
REQ-014 Reset asserted mid-operation SHALL immediately discard all checkpoints and all pending writes.

Configuration
REQ-015 When MT_CDB_BYPASS_EN is defined, a non-forwarded source whose pr matches a valid cdb_pr in the same cycle SHALL report ready=1. When it is undefined, ready SHALL reflect only the registered state, so a completion becomes visible one cycle later.

Verification
REQ-016 After reset, dispatch 2 slots with dest r3/r4, fl_pr 32/33 and sources r5..r8 -> told=3/4, src_pr=5..8, all ready=1.
REQ-017 On the next cycle, sources r3/r4 -> src_pr=32/33, ready=0. CDB lanes 32/33 valid that cycle -> ready=1 with MT_CDB_BYPASS_EN defined, ready=0 without it. In the following cycle -> ready=1 in both builds.
REQ-018 Both slots with dest r19, fl_pr 40/41 -> told0=19, told1=40; map[19]=41 afterwards.
REQ-019 Slot 0 has dest r20 with fl_pr 41; slot 1 has src1 r20 -> slot 1 src1_pr=41, ready=0.
REQ-020 Take a checkpoint (ckpt_slot=0) on r1→50, then rename r1→51, then recover that tag -> r1 reads 50 and count=0. Take 4 checkpoints -> ckpt_full=1; a 5th take is ignored.
